// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: E0/F0 prefix tracking, Shift/Caps Lock state,
// ASCII translation and a small event FIFO drained over valid/ready.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       shift_held,
    output logic       caps_lock,
    output logic [7:0] release_count,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ev_t;

    state_t      state;
    logic        shift_l, shift_r, caps_down;
    ev_t         mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        emit, cur_ext, cur_brk, empty, full, pop, push_ok;
    ev_t         new_ev, head;

    // Lowercase letters are looked up first; case is applied afterwards.
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [7:0] a;
        logic       letter;
        a      = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            default: letter = 1'b0;
        endcase
        if (letter) begin
            if (upper) a = a - 8'h20;
        end else begin
            case (code)
                8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
                8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
                8'h3E: a = 8'h38;  8'h46: a = 8'h39;  8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    assign shift_held = shift_l | shift_r;
    assign emit       = in_valid && (in_data != 8'hE0) && (in_data != 8'hF0);
    assign cur_ext    = (state == S_E0) || (state == S_E0F0);
    assign cur_brk    = (state == S_F0) || (state == S_E0F0);

    always_comb begin
        new_ev.code  = in_data;
        new_ev.ext   = cur_ext;
        new_ev.brk   = cur_brk;
        new_ev.ascii = cur_ext ? 8'h00 : ascii_of(in_data, shift_held ^ caps_lock);
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && ev_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = emit && (!full || pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            shift_l       <= 1'b0;
            shift_r       <= 1'b0;
            caps_lock     <= 1'b0;
            caps_down     <= 1'b0;
            release_count <= 8'h00;
        end else if (in_valid) begin
            if (in_data == 8'hE0) begin
                state <= S_E0;
            end else if (in_data == 8'hF0) begin
                if (state == S_IDLE)    state <= S_F0;
                else if (state == S_E0) state <= S_E0F0;
            end else begin
                state <= S_IDLE;
                if (cur_brk) release_count <= release_count + 8'd1;
                if (!cur_ext) begin
                    if (in_data == 8'h12) shift_l <= !cur_brk;
                    if (in_data == 8'h59) shift_r <= !cur_brk;
                    // caps_down masks typematic repeats of the Caps Lock make code.
                    if (in_data == 8'h58) begin
                        if (cur_brk) begin
                            caps_down <= 1'b0;
                        end else begin
                            if (!caps_down) caps_lock <= !caps_lock;
                            caps_down <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)           wr_ptr   <= wr_ptr + PTR_ONE;
            if (pop)               rd_ptr   <= rd_ptr + PTR_ONE;
            if (emit && !push_ok)  overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= new_ev;
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign ev_valid = !empty;
    assign ev_code  = ev_valid ? head.code  : 8'h00;
    assign ev_ext   = ev_valid ? head.ext   : 1'b0;
    assign ev_break = ev_valid ? head.brk   : 1'b0;
    assign ev_ascii = ev_valid ? head.ascii : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios plus random byte streams
// checked against a queue-based behavioural model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ev_t;

    logic       clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, ev_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       ev_valid, ev_ext, ev_break, shift_held, caps_lock, overflow;
    logic [7:0] ev_code, ev_ascii, release_count;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .ev_ascii(ev_ascii), .shift_held(shift_held),
        .caps_lock(caps_lock), .release_count(release_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    logic [7:0] LETTER_CODES [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] DIGIT_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46};

    // Model state: pending prefix flags, modifiers, counters and queues.
    ev_t        mq[$], exp_q[$], got_q[$];
    logic       m_ext, m_brk, m_shl, m_shr, m_caps, m_cdown, m_ovf;
    logic [7:0] m_rel;

    function automatic logic [7:0] model_ascii(input logic [7:0] c);
        logic upper;
        upper = (m_shl | m_shr) ^ m_caps;
        for (int i = 0; i < 26; i++)
            if (LETTER_CODES[i] == c) return upper ? 8'(8'h41 + i) : 8'(8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (DIGIT_CODES[i] == c) return 8'(8'h30 + i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_clear();
        mq.delete(); exp_q.delete(); got_q.delete();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_cdown = 0; m_ovf = 0;
        m_rel = 8'h00;
    endtask

    task automatic do_reset();
        resetn = 1'b0; in_valid = 1'b0; ev_ready = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_clear();
    endtask

    // One clock cycle: drive inputs, record any DUT pop, advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        ev_t  e;
        int   sz;
        logic mpop, emitted, acc;
        in_valid = v; in_data = d; ev_ready = r;
        @(negedge clk);
        if (ev_valid && ev_ready) got_q.push_back(ev_t'{ev_code, ev_ext, ev_break, ev_ascii});
        sz = mq.size(); mpop = r && (sz > 0); emitted = 0; acc = 0; e = '0;
        if (v && d == 8'hE0) begin
            m_ext = 1; m_brk = 0;
        end else if (v && d == 8'hF0) begin
            m_brk = 1;
        end else if (v) begin
            emitted = 1;
            e = ev_t'{d, m_ext, m_brk, m_ext ? 8'h00 : model_ascii(d)};
            if (!m_ext) begin
                if (d == 8'h12) m_shl = !m_brk;
                if (d == 8'h59) m_shr = !m_brk;
                if (d == 8'h58) begin
                    if (m_brk) m_cdown = 0;
                    else begin
                        if (!m_cdown) m_caps = !m_caps;
                        m_cdown = 1;
                    end
                end
            end
            if (m_brk) m_rel = m_rel + 8'd1;
            acc = (sz < DEPTH) || mpop;
            m_ext = 0; m_brk = 0;
        end
        if (mpop) exp_q.push_back(mq.pop_front());
        if (emitted) begin
            if (acc) mq.push_back(e);
            else m_ovf = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b exp 0", ev_valid); end
        checks++; if ({ev_code, ev_ext, ev_break, ev_ascii} !== 18'h0) begin errors++;
            $display("FAIL reset_ev_fields got %h %b %b %h exp 0", ev_code, ev_ext, ev_break, ev_ascii); end
        checks++; if ({shift_held, caps_lock, overflow} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got %b%b%b exp 000", shift_held, caps_lock, overflow); end
        checks++; if (release_count !== 8'h00) begin errors++; $display("FAIL reset_relcnt got %h exp 00", release_count); end
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 8'h1C, 0);
        checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h1C) begin errors++;
            $display("FAIL latency got valid %b code %h exp 1 1c", ev_valid, ev_code); end
        step(0, 8'h00, 1);
        step(1, 8'hF0, 1); step(1, 8'h1C, 1);
        repeat (2) step(0, 8'h00, 1);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL basic_count got %0d exp 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ev_t'{8'h1C, 1'b0, 1'b0, 8'h61}) begin errors++; $display("FAIL basic_make got %h exp 1c0061", got_q[0]); end
            checks++; if (got_q[1] !== ev_t'{8'h1C, 1'b0, 1'b1, 8'h61}) begin errors++; $display("FAIL basic_break got %h exp 1c1061", got_q[1]); end
        end
        checks++; if (release_count !== 8'h01) begin errors++; $display("FAIL basic_relcnt got %h exp 01", release_count); end
    endtask

    task automatic test_modifiers();
        do_reset();
        step(1, 8'h12, 1); step(1, 8'h1C, 1); step(1, 8'hF0, 1); step(1, 8'h12, 1);
        step(1, 8'h58, 1); step(1, 8'h58, 1);
        checks++; if (caps_lock !== 1'b1) begin errors++; $display("FAIL caps_after_repeat got %b exp 1", caps_lock); end
        step(1, 8'hF0, 1); step(1, 8'h58, 1); step(1, 8'h1C, 1);
        repeat (2) step(0, 8'h00, 1);
        checks++; if (shift_held !== 1'b0) begin errors++; $display("FAIL shift_end got %b exp 0", shift_held); end
        checks++; if (got_q.size() != 7) begin errors++; $display("FAIL mod_count got %0d exp 7", got_q.size()); end
        else begin
            checks++; if (got_q[1].ascii !== 8'h41) begin errors++; $display("FAIL shift_ascii got %h exp 41", got_q[1].ascii); end
            checks++; if (got_q[6].ascii !== 8'h41) begin errors++; $display("FAIL caps_ascii got %h exp 41", got_q[6].ascii); end
            for (int i = 0; i < 7; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mod_event[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_extended();
        do_reset();
        step(1, 8'h12, 1);
        step(1, 8'hE0, 1); step(1, 8'h75, 1);
        step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h75, 1);
        step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h12, 1);
        repeat (2) step(0, 8'h00, 1);
        checks++; if (shift_held !== 1'b1 || caps_lock !== 1'b0) begin errors++;
            $display("FAIL ext_mods got shift %b caps %b exp 1 0", shift_held, caps_lock); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL ext_count got %0d exp 4", got_q.size()); end
        else begin
            checks++; if (got_q[1] !== ev_t'{8'h75, 1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL ext_make got %h exp 752000", got_q[1]); end
            checks++; if (got_q[2] !== ev_t'{8'h75, 1'b1, 1'b1, 8'h00}) begin errors++; $display("FAIL ext_break got %h exp 753000", got_q[2]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        do_reset();
        for (int i = 0; i < 9; i++) step(1, codes[i], 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        step(0, 8'h00, 0);
        checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h1C || ev_ascii !== 8'h61) begin errors++;
            $display("FAIL ovf_head_stable got %b %h %h exp 1 1c 61", ev_valid, ev_code, ev_ascii); end
        repeat (12) step(0, 8'h00, 1);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL ovf_drain_count got %0d exp 8", got_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++; if (got_q[i].code !== codes[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, got_q[i].code, codes[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, DIGIT_CODES[i], 0);
        step(1, 8'h46, 1);
        checks++; if (overflow !== 1'b0 || ev_valid !== 1'b1) begin errors++;
            $display("FAIL full_pushpop got ovf %b valid %b exp 0 1", overflow, ev_valid); end
        repeat (12) step(0, 8'h00, 1);
        checks++; if (got_q.size() != 9) begin errors++; $display("FAIL full_total got %0d exp 9", got_q.size()); end
        else begin
            checks++; if (got_q[8] !== ev_t'{8'h46, 1'b0, 1'b0, 8'h39}) begin errors++; $display("FAIL full_last got %h exp 460039", got_q[8]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 8'h1C, 0);
        step(1, 8'hE0, 0); step(1, 8'hF0, 0);
        do_reset();
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flush got %b exp 0", ev_valid); end
        step(1, 8'h1C, 1);
        repeat (2) step(0, 8'h00, 1);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ev_t'{8'h1C, 1'b0, 1'b0, 8'h61}) begin errors++; $display("FAIL rstmid_event got %h exp 1c0061", got_q[0]); end
        end
    endtask

    task automatic test_release_wrap();
        int bad;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1, 8'hF0, 1); step(1, 8'h16, 1);
            if (i == 254) begin
                checks++; if (release_count !== 8'hFF) begin errors++; $display("FAIL relcnt_ff got %h exp ff", release_count); end
            end
        end
        repeat (2) step(0, 8'h00, 1);
        checks++; if (release_count !== 8'h00) begin errors++; $display("FAIL relcnt_wrap got %h exp 00", release_count); end
        checks++; if (got_q.size() != 256) begin errors++; $display("FAIL wrap_count got %0d exp 256", got_q.size()); end
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== ev_t'{8'h16, 1'b0, 1'b1, 8'h31}) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_events got %0d bad exp 0", bad); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       v, r;
        int         sel;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 15));
            case (sel)
                0, 1:    d = 8'hE0;
                2, 3:    d = 8'hF0;
                4:       d = 8'h12;
                5:       d = 8'h59;
                6:       d = 8'h58;
                7:       d = 8'h29;
                8:       d = 8'h5A;
                9:       d = 8'($urandom);
                10, 11:  d = DIGIT_CODES[$urandom_range(0, 9)];
                default: d = LETTER_CODES[$urandom_range(0, 25)];
            endcase
            v = ($urandom_range(0, 3) != 0);
            r = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(v, d, r);
            checks++; if (ev_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, ev_valid, mq.size() != 0); end
            checks++; if ({shift_held, caps_lock, overflow} !== {m_shl | m_shr, m_caps, m_ovf}) begin errors++;
                $display("FAIL rnd_flags[%0d] got %b%b%b exp %b%b%b", i, shift_held, caps_lock, overflow, m_shl | m_shr, m_caps, m_ovf); end
            checks++; if (release_count !== m_rel) begin errors++; $display("FAIL rnd_relcnt[%0d] got %h exp %h", i, release_count, m_rel); end
        end
        repeat (12) step(0, 8'h00, 1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_event[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_modifiers();
        test_extended();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_release_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 receive stage and turns PS/2 set-2 scan codes into key events. It handles the E0/F0 prefix sequences, tracks Shift and Caps Lock state, and translates letters, digits, Space and Enter to ASCII. Completed events are buffered in a small FIFO and drained over a valid/ready handshake by the console/MMIO side of the design.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; must be a power of two and at least 2.
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  one-cycle strobe; one received byte per strobe; may be high on any cycle.
- in_data  in  8  received byte; sampled only when in_valid=1.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle when ev_valid=1.
- ev_code  out  8  final (non-prefix) scan code of the head event.
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a release (F0-prefixed).
- ev_ascii  out  8  ASCII of the head event; 0x00 if the key is unmapped.
- shift_held  out  1  left Shift (0x12) or right Shift (0x59) is down; non-extended codes only.
- caps_lock  out  1  Caps Lock toggle state.
- release_count  out  8  number of break events decoded, modulo 256.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Prefix FSM with states IDLE, E0, F0 and E0F0. The FSM acts only on cycles with in_valid=1.
  - Byte 0xE0, any state -> E0. A stray E0 restarts the sequence.
  - Byte 0xF0: IDLE -> F0; E0 -> E0F0; F0 stays in F0; E0F0 stays in E0F0.
  - Any other byte: emit an event, then -> IDLE.
    - ev_ext is 1 in states E0 and E0F0.
    - ev_break is 1 in states F0 and E0F0.
- Every emitted event is a push. This includes modifier keys and typematic repeats; there is no repeat suppression.
- Modifiers, non-extended codes only:
  - 0x12 and 0x59 each drive their own held bit: set on make, clear on break.
  - 0x58 make toggles caps_lock only when the internal caps_down flag is 0, then sets caps_down. 0x58 break clears caps_down. Repeated makes therefore do not toggle.
- ASCII is computed only for non-extended events, using the modifier state from before this byte's update. All other events get ascii 0x00.
  - Letters: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
  - Letter case: uppercase (0x41-0x5A) when shift_held XOR caps_lock; otherwise lowercase (0x61-0x7A).
  - Digits: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46, giving 0x30-0x39 regardless of Shift.
  - Space 0x29 -> 0x20. Enter 0x5A (non-extended) -> 0x0D.
  - Break events carry the same ASCII rule as make events.
- release_count increments on every emitted break event and wraps 0xFF -> 0x00.
- FIFO:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the event is dropped and overflow is set. The FSM, modifiers and release_count still update.
  - A pop occurs when ev_valid and ev_ready are both 1.
  - ev_ready while empty has no effect.

## Timing
- Reset (resetn=0 at a clk edge):
  - FSM -> IDLE; FIFO empty.
  - ev_valid=0, shift_held=0, caps_lock=0, caps_down=0, release_count=0, overflow=0.
  - ev_code, ev_ext, ev_break and ev_ascii read 0 while ev_valid=0.
  - Reset mid-sequence discards any pending prefix and all queued events.
- Latency: final byte strobed in cycle N -> ev_valid=1 in cycle N+1 if the FIFO was empty. There is no combinational path from in_* to ev_*.
- Modifier outputs and release_count update at the end of cycle N.
- FIFO full with push and pop in the same cycle: both happen, the FIFO stays full, and overflow is unchanged.
- FIFO empty with push and pop: no bypass; the pop is ignored because ev_valid=0.
- ev_* remain stable while ev_valid=1 and ev_ready=0.
- A prefix byte and an event byte on back-to-back cycles must both be handled; full rate is one byte per cycle.

## Test plan
- Stimulus 1C, F0 1C with ev_ready=1 -> events {1C, ext0, brk0, 0x61} then {1C, ext0, brk1, 0x61}; release_count=1.
- Stimulus 12, 1C, F0 12, 58, 58, F0 58, 1C:
  - Event ASCII: 0x41 for the 1C under Shift, 0x41 for the 1C under Caps Lock.
  - caps_lock=1 after the two 0x58 makes (toggled once).
  - shift_held=0 at the end.
- Stimulus E0 75, E0 F0 75 -> {75, ext1, brk0, 0x00} and {75, ext1, brk1, 0x00}; shift_held and caps_lock unchanged.
- ev_ready=0, push 9 make codes with FIFO_DEPTH=8 -> 8 events queued in order, the 9th dropped, overflow=1. Then drain with ev_ready=1 -> exactly 8 events, overflow remains 1.
- FIFO full, push and pop in the same cycle -> count stays 8 and overflow stays 0. Assert resetn=0 after E0 F0 -> a following 1C emits {1C, ext0, brk0}.
- Stimulus F0 ×256 paired with 16 -> release_count wraps to 0x00; every event has ascii 0x31.
